// File: rtl/frame_buffer_scheduler_if.sv
// Bundle of every non-clock signal of frame_buffer_scheduler.
// Ports: camera capture (capture_req, cam_*), status (capturing, frame_ready),
// two read requesters (rd_*), and the single-port RAM bus (mem_*).
interface frame_buffer_scheduler_if #(
  parameter int X_WIDTH    = 9,
  parameter int Y_WIDTH    = 8,
  parameter int ADDR_WIDTH = 17,
  parameter int DATA_WIDTH = 16
);
  logic                  capture_req;
  logic                  cam_vsync;
  logic                  cam_valid;
  logic [DATA_WIDTH-1:0] cam_data;
  logic                  capturing;
  logic                  frame_ready;
  logic [1:0]            rd_req;
  logic [X_WIDTH-1:0]    rd_x0;
  logic [X_WIDTH-1:0]    rd_x1;
  logic [Y_WIDTH-1:0]    rd_y0;
  logic [Y_WIDTH-1:0]    rd_y1;
  logic [1:0]            rd_ack;
  logic [DATA_WIDTH-1:0] rd_data;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_we;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;

  // The scheduler side
  modport master (
    input  capture_req, cam_vsync, cam_valid, cam_data,
    input  rd_req, rd_x0, rd_x1, rd_y0, rd_y1, mem_rdata,
    output capturing, frame_ready, rd_ack, rd_data,
    output mem_addr, mem_we, mem_wdata
  );

  // The camera / requester / RAM side
  modport slave (
    output capture_req, cam_vsync, cam_valid, cam_data,
    output rd_req, rd_x0, rd_x1, rd_y0, rd_y1, mem_rdata,
    input  capturing, frame_ready, rd_ack, rd_data,
    input  mem_addr, mem_we, mem_wdata
  );
endinterface

// File: rtl/frame_buffer_scheduler.sv
// Sole owner of the single-port frame buffer RAM: captures one camera frame
// per request and serves two (x,y) read ports in the gaps between writes.
// Ports: clk, rst (async, active-high), bus (frame_buffer_scheduler_if.master).
// Writes are issued combinationally in the cam_valid cycle; reads are granted
// in cycle G (address out) and acknowledged with data in G+1.
module frame_buffer_scheduler #(
  parameter int X_COUNT    = 320,
  parameter int Y_COUNT    = 240,
  parameter int X_WIDTH    = 9,
  parameter int Y_WIDTH    = 8,
  parameter int ADDR_WIDTH = 17,
  parameter int DATA_WIDTH = 16
) (
  input logic                     clk,
  input logic                     rst,
  frame_buffer_scheduler_if.master bus
);
  localparam int                    SIZE = X_COUNT * Y_COUNT;
  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(SIZE - 1);

  typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DONE} state_t;

  state_t                state, state_nxt;
  logic                  vsync_q;
  logic                  vsync_rise;
  logic [ADDR_WIDTH-1:0] widx, widx_nxt, wr_addr;
  logic                  wr;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [1:0]            ack_q;
  logic                  oob_q;
  logic                  favour1;
  logic [1:0]            elig, grant;
  logic [X_WIDTH-1:0]    gx;
  logic [Y_WIDTH-1:0]    gy;
  logic                  in_range;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [ADDR_WIDTH-1:0] mem_addr_c;
  logic [DATA_WIDTH-1:0] mem_wdata_c;

  assign vsync_rise = bus.cam_vsync & ~vsync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state, write index and the write strobe
  always_comb begin
    state_nxt = state;
    widx_nxt  = widx;
    wr_addr   = widx;
    wr        = 1'b0;
    case (state)
      IDLE:    if (bus.capture_req) state_nxt = ARMED;
      ARMED:   if (vsync_rise) begin
                 state_nxt = CAPTURE;
                 widx_nxt  = '0;
               end
      CAPTURE: begin
        // A vsync edge mid-frame resynchronises; a pixel in the same cycle
        // lands at address 0.
        if (vsync_rise) begin
          wr_addr  = '0;
          widx_nxt = '0;
        end
        if (bus.cam_valid) begin
          wr = 1'b1;
          if (wr_addr == LAST) begin
            state_nxt = DONE;
            widx_nxt  = '0;
          end else begin
            widx_nxt = wr_addr + ADDR_WIDTH'(1);
          end
        end
      end
      DONE:    if (bus.capture_req) state_nxt = ARMED;
      default: state_nxt = IDLE;
    endcase
  end

  // Read arbitration: writes always win; a port whose ack is pending is masked.
  always_comb begin
    elig  = bus.rd_req & ~ack_q;
    grant = 2'b00;
    if (!rst && !wr) begin
      if (elig == 2'b11) grant = favour1 ? 2'b10 : 2'b01;
      else               grant = elig;
    end
    gx       = grant[1] ? bus.rd_x1 : bus.rd_x0;
    gy       = grant[1] ? bus.rd_y1 : bus.rd_y0;
    in_range = (int'(gx) < X_COUNT) && (int'(gy) < Y_COUNT);
    rd_addr  = ADDR_WIDTH'(gy) * ADDR_WIDTH'(X_COUNT) + ADDR_WIDTH'(gx);
  end

  // RAM bus: address and write data hold their last driven value when idle.
  always_comb begin
    mem_addr_c  = addr_q;
    mem_wdata_c = wdata_q;
    if (wr) begin
      mem_addr_c  = wr_addr;
      mem_wdata_c = bus.cam_data;
    end else if ((|grant) && in_range) begin
      mem_addr_c = rd_addr;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vsync_q <= 1'b0;
      widx    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      ack_q   <= 2'b00;
      oob_q   <= 1'b0;
      favour1 <= 1'b0;
    end else begin
      vsync_q <= bus.cam_vsync;
      widx    <= widx_nxt;
      addr_q  <= mem_addr_c;
      wdata_q <= mem_wdata_c;
      ack_q   <= grant;
      oob_q   <= (|grant) && !in_range;
      // The tie pointer only moves when a tie is actually resolved, so the
      // loser of one tie is guaranteed to win the next one.
      if (elig == 2'b11 && (|grant)) favour1 <= grant[0];
    end
  end

  assign bus.mem_addr    = mem_addr_c;
  assign bus.mem_wdata   = mem_wdata_c;
  assign bus.mem_we      = wr;
  assign bus.rd_ack      = ack_q;
  assign bus.rd_data     = ((|ack_q) && !oob_q) ? bus.mem_rdata : '0;
  assign bus.capturing   = (state == ARMED) || (state == CAPTURE);
  // Drops in the very cycle a new capture is requested.
  assign bus.frame_ready = (state == DONE) && !bus.capture_req;
endmodule

// File: tb/tb_frame_buffer_scheduler.sv
module tb_frame_buffer_scheduler;
  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;
  int   wr_err = 0;

  always #5 clk = ~clk;

  frame_buffer_scheduler_if #(.X_WIDTH(9), .Y_WIDTH(8), .ADDR_WIDTH(17), .DATA_WIDTH(16)) bus ();

  frame_buffer_scheduler dut (.clk(clk), .rst(rst), .bus(bus));

  // Single-port RAM model, one-cycle synchronous read
  logic [15:0] ram [0:76799];
  always @(posedge clk) begin
    if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
    bus.mem_rdata <= ram[bus.mem_addr];
  end

  typedef struct {
    logic [1:0]  req;
    logic [8:0]  x0;
    logic [7:0]  y0;
    logic [8:0]  x1;
    logic [7:0]  y1;
    logic [16:0] addr;
    logic [1:0]  ack;
    logic [15:0] data;
  } vec_t;

  vec_t vecs [16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Drive one pixel and tally whether the write lands where expected.
  task automatic pixel(input int a, input logic [15:0] d, input logic vs);
    bus.cam_valid = 1'b1;
    bus.cam_data  = d;
    bus.cam_vsync = vs;
    #2;
    if (bus.mem_we !== 1'b1 || bus.mem_addr !== 17'(a) || bus.mem_wdata !== d) wr_err++;
  endtask

  initial begin
    rst             = 1'b1;
    bus.capture_req = 1'b0;
    bus.cam_vsync   = 1'b0;
    bus.cam_valid   = 1'b0;
    bus.cam_data    = '0;
    bus.rd_req      = 2'b00;
    bus.rd_x0 = '0; bus.rd_y0 = '0; bus.rd_x1 = '0; bus.rd_y1 = '0;

    // Read vectors in DONE; RAM holds ram[a] = a[15:0].
    vecs[0]  = '{2'b01, 9'd5,   8'd2,   9'd0,   8'd0,   17'd645,   2'b00, 16'd0};
    vecs[1]  = '{2'b00, 9'd0,   8'd0,   9'd0,   8'd0,   17'd645,   2'b01, 16'd645};
    vecs[2]  = '{2'b11, 9'd0,   8'd0,   9'd319, 8'd239, 17'd0,     2'b00, 16'd0};
    vecs[3]  = '{2'b10, 9'd0,   8'd0,   9'd319, 8'd239, 17'd76799, 2'b01, 16'd0};
    vecs[4]  = '{2'b00, 9'd0,   8'd0,   9'd0,   8'd0,   17'd76799, 2'b10, 16'd11263};
    vecs[5]  = '{2'b11, 9'd5,   8'd2,   9'd1,   8'd0,   17'd1,     2'b00, 16'd0};
    vecs[6]  = '{2'b01, 9'd5,   8'd2,   9'd1,   8'd0,   17'd645,   2'b10, 16'd1};
    vecs[7]  = '{2'b00, 9'd0,   8'd0,   9'd0,   8'd0,   17'd645,   2'b01, 16'd645};
    vecs[8]  = '{2'b01, 9'd320, 8'd0,   9'd0,   8'd0,   17'd645,   2'b00, 16'd0};
    vecs[9]  = '{2'b00, 9'd0,   8'd0,   9'd0,   8'd0,   17'd645,   2'b01, 16'd0};
    vecs[10] = '{2'b10, 9'd0,   8'd0,   9'd0,   8'd240, 17'd645,   2'b00, 16'd0};
    vecs[11] = '{2'b00, 9'd0,   8'd0,   9'd0,   8'd0,   17'd645,   2'b10, 16'd0};
    vecs[12] = '{2'b01, 9'd2,   8'd0,   9'd0,   8'd0,   17'd2,     2'b00, 16'd0};
    vecs[13] = '{2'b01, 9'd2,   8'd0,   9'd0,   8'd0,   17'd2,     2'b01, 16'd2};
    vecs[14] = '{2'b01, 9'd3,   8'd0,   9'd0,   8'd0,   17'd3,     2'b00, 16'd0};
    vecs[15] = '{2'b00, 9'd0,   8'd0,   9'd0,   8'd0,   17'd3,     2'b01, 16'd3};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset capturing", 32'(bus.capturing), 0);
    check("reset frame_ready", 32'(bus.frame_ready), 0);
    check("reset rd_ack", 32'(bus.rd_ack), 0);
    check("reset mem_we", 32'(bus.mem_we), 0);
    check("reset mem_addr", 32'(bus.mem_addr), 0);
    check("reset mem_wdata", 32'(bus.mem_wdata), 0);
    check("reset rd_data", 32'(bus.rd_data), 0);
    rst = 1'b0;
    cyc();

    // Arm, and confirm pixels before vsync are ignored
    bus.capture_req = 1'b1;
    cyc();
    bus.capture_req = 1'b0;
    bus.cam_valid   = 1'b1;
    bus.cam_data    = 16'hBEEF;
    #2;
    check("armed capturing", 32'(bus.capturing), 1);
    check("armed pixel ignored", 32'(bus.mem_we), 0);
    cyc();
    bus.cam_valid = 1'b0;
    bus.cam_vsync = 1'b1;
    cyc();
    bus.cam_vsync = 1'b0;

    // 100 pixels, then a resync edge coinciding with pixel 0
    for (int i = 0; i < 100; i++) begin
      bus.capture_req = (i == 50);
      pixel(i, 16'(32'hA000 + i), 1'b0);
      cyc();
    end
    bus.capture_req = 1'b0;
    check("capture_req ignored in CAPTURE", 32'(bus.capturing), 1);
    pixel(0, 16'd0, 1'b1);
    check("resync pixel addr", 32'(bus.mem_addr), 0);
    cyc();
    bus.cam_vsync = 1'b0;
    for (int i = 1; i < 1000; i++) begin
      pixel(i, 16'(i), 1'b0);
      cyc();
    end

    // Port 1 asks during a 3-pixel burst; granted in the first idle cycle
    bus.rd_req = 2'b10;
    bus.rd_x1  = 9'd1;
    bus.rd_y1  = 8'd0;
    for (int k = 0; k < 3; k++) begin
      pixel(1000 + k, 16'(1000 + k), 1'b0);
      check("no grant during write", 32'(bus.rd_ack), 0);
      cyc();
    end
    bus.cam_valid = 1'b0;
    #2;
    check("gap cycle mem_we", 32'(bus.mem_we), 0);
    check("gap cycle grant addr", 32'(bus.mem_addr), 1);
    cyc();
    bus.rd_req = 2'b00;
    pixel(1003, 16'd1003, 1'b0);
    check("mid-capture ack", 32'(bus.rd_ack), 32'b10);
    check("mid-capture rd_data", 32'(bus.rd_data), 1);
    cyc();

    for (int i = 1004; i < 76799; i++) begin
      pixel(i, 16'(i), 1'b0);
      cyc();
    end
    pixel(76799, 16'(76799), 1'b0);
    check("not done before last write", 32'(bus.frame_ready), 0);
    cyc();
    bus.cam_valid = 1'b0;
    #2;
    check("frame write sequence errors", 32'(wr_err), 0);
    check("frame_ready after last", 32'(bus.frame_ready), 1);
    check("capturing after last", 32'(bus.capturing), 0);
    check("ram[0] overwritten after resync", 32'(ram[0]), 0);
    check("ram[99] overwritten after resync", 32'(ram[99]), 99);
    bus.cam_valid = 1'b1;
    #1;
    check("DONE pixel ignored", 32'(bus.mem_we), 0);
    cyc();
    bus.cam_valid = 1'b0;

    // Table-driven reads in DONE
    for (int v = 0; v < 16; v++) begin
      bus.rd_req = vecs[v].req;
      bus.rd_x0  = vecs[v].x0;
      bus.rd_y0  = vecs[v].y0;
      bus.rd_x1  = vecs[v].x1;
      bus.rd_y1  = vecs[v].y1;
      #2;
      check($sformatf("vec%0d mem_we", v), 32'(bus.mem_we), 0);
      check($sformatf("vec%0d mem_addr", v), 32'(bus.mem_addr), 32'(vecs[v].addr));
      check($sformatf("vec%0d rd_ack", v), 32'(bus.rd_ack), 32'(vecs[v].ack));
      if (vecs[v].ack != 2'b00)
        check($sformatf("vec%0d rd_data", v), 32'(bus.rd_data), 32'(vecs[v].data));
      cyc();
    end
    bus.rd_req = 2'b00;

    // Re-arm from DONE
    bus.capture_req = 1'b1;
    #2;
    check("frame_ready drops with capture_req", 32'(bus.frame_ready), 0);
    cyc();
    bus.capture_req = 1'b0;
    #1;
    check("re-armed capturing", 32'(bus.capturing), 1);
    bus.cam_vsync = 1'b1;
    cyc();
    bus.cam_vsync = 1'b0;

    // Reset in the ack cycle of a read while a pixel is being written
    bus.rd_req = 2'b01;
    bus.rd_x0  = 9'd5;
    bus.rd_y0  = 8'd2;
    #2;
    check("pre-reset grant addr", 32'(bus.mem_addr), 645);
    cyc();
    bus.rd_req = 2'b00;
    pixel(0, 16'd7, 1'b0);
    check("pre-reset ack", 32'(bus.rd_ack), 1);
    check("pre-reset write", 32'(bus.mem_we), 1);
    rst = 1'b1;
    #1;
    check("mid reset rd_ack", 32'(bus.rd_ack), 0);
    check("mid reset mem_we", 32'(bus.mem_we), 0);
    check("mid reset capturing", 32'(bus.capturing), 0);
    check("mid reset frame_ready", 32'(bus.frame_ready), 0);
    check("mid reset mem_addr", 32'(bus.mem_addr), 0);
    bus.cam_valid = 1'b0;
    cyc();
    rst = 1'b0;
    cyc();
    bus.cam_vsync = 1'b1;
    cyc();
    bus.cam_vsync = 1'b0;
    cyc();
    check("idle ignores vsync", 32'(bus.capturing), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/frame_buffer_scheduler.md
Name: frame_buffer_scheduler

Overview: Owns the single-port frame buffer RAM and sequences all access to it. Captures one camera frame on request, writing pixels at linear addresses 0..SIZE-1. Between writes it serves two random-access read requesters: display (port 0) and colour sampler (port 1). Each reader supplies (x,y) coordinates, and the block converts them to linear addresses.

Parameters:
X_COUNT, 320, pixels per line
Y_COUNT, 240, lines per frame
X_WIDTH, 9, width of x coordinates
Y_WIDTH, 8, width of y coordinates
ADDR_WIDTH, 17, RAM address width; SIZE = X_COUNT*Y_COUNT must fit
DATA_WIDTH, 16, pixel width (RGB565)

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
capture_req  in  1  single-cycle pulse: arm a one-frame capture
cam_vsync  in  1  camera frame sync, already synchronised to clk
cam_valid  in  1  camera pixel strobe, at most one per cycle
cam_data  in  DATA_WIDTH  camera pixel
capturing  out  1  high in ARMED or CAPTURE
frame_ready  out  1  high in DONE
rd_req[1:0]  in  2  per-port read request, level, held until ack
rd_x0/rd_x1  in  X_WIDTH  read x coordinate per port
rd_y0/rd_y1  in  Y_WIDTH  read y coordinate per port
rd_ack[1:0]  out  2  per-port single-cycle acknowledge
rd_data  out  DATA_WIDTH  read data, valid while any rd_ack is high
mem_addr  out  ADDR_WIDTH  RAM address
mem_we  out  1  RAM write enable
mem_wdata  out  DATA_WIDTH  RAM write data
mem_rdata  in  DATA_WIDTH  RAM read data, one-cycle synchronous latency

Behaviour:
- Reset: state IDLE. capturing, frame_ready, rd_ack, mem_we = 0. mem_addr, mem_wdata, rd_data, write index = 0. Round-robin pointer favours port 0.
- FSM transitions:
  - IDLE -> ARMED on capture_req.
  - ARMED -> CAPTURE on a vsync rising edge (cam_vsync 0 in the previous cycle, 1 in this one). Write index = 0.
  - CAPTURE: each cam_valid issues a write in the same cycle: mem_we=1, mem_addr=index, mem_wdata=cam_data, then index+1.
  - CAPTURE -> DONE: the write at index SIZE-1 moves the FSM to DONE and wraps the index to 0.
  - DONE -> ARMED on capture_req. frame_ready clears in that cycle.
- capture_req in ARMED or CAPTURE is ignored.
- Vsync rising edge during CAPTURE: index restarts at 0 and the FSM stays in CAPTURE. This covers partial-frame resync. If cam_valid occurs in the same cycle, that pixel is written to address 0 and index becomes 1.
- cam_valid outside CAPTURE is ignored. No write occurs.
- Arbitration, evaluated every cycle:
  - A camera write always wins.
  - Otherwise grant one eligible read. If both ports are eligible, grant the port that was not granted last (round-robin). A single eligible port is granted immediately.
- Read timing:
  - Grant cycle G: mem_we=0, mem_addr = y*X_COUNT + x, computed in ADDR_WIDTH unsigned.
  - Cycle G+1: rd_ack[p]=1 and rd_data=mem_rdata.
- Eligibility: rd_req[p]=1 and port p has no grant in flight. This masks the ack cycle, so a port can be granted at most every 2nd cycle. The requester drops or changes its request in the ack cycle. A new request is sampled from G+2.
- Out-of-range coordinates (x>=X_COUNT or y>=Y_COUNT): the grant is consumed but no address is driven. mem_addr holds its previous value. Ack at G+1 returns rd_data=0.
- Reads are permitted in every state, including mid-capture in cycles without cam_valid. Data written before the current cycle is visible.
- mem_addr holds its last value when idle. mem_we is high only on write cycles.
- Reset mid-operation: immediate return to the reset values. Any in-flight ack is dropped and the partial frame is abandoned.

Test Plan:
- Reset, pulse capture_req, then one vsync rise followed by 76800 cam_valid pixels of data=index[15:0]. Required: writes to addresses 0..76799, frame_ready=1 after the last write, and capturing=0.
- In DONE, port 0 reads (x=5,y=2). Required: mem_addr=645 in G, rd_ack[0] at G+1, rd_data=645.
- Both ports request at once, with port 0 at (0,0) and port 1 at (319,239). Required: port 0 granted first (addr 0), port 1 in the next cycle (addr 76799), acks one cycle apart, and port 1 wins the next tie.
- During CAPTURE, port 1 requests while cam_valid is asserted for 3 cycles. Required: no read grant during the writes, and the grant happens in the first cycle with cam_valid=0.
- Vsync rises after 100 pixels. Required: the next pixel is written to address 0, and the frame completes only after 76800 further pixels.
- Read (x=320,y=0) returns ack with data 0 and no RAM address change. Asserting rst mid-capture forces IDLE, frame_ready=0, rd_ack=0, and mem_we=0 immediately.
